// File: rtl/lcd_ci_timed.sv
// Nios II multi-cycle custom instruction that performs one timed HD44780 write
// (8-bit or 4-bit bus), waits out the LCD busy time and returns done/result.
module lcd_ci_timed #(
  parameter int unsigned FOUR_BIT = 0,
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_EN     = 12,
  parameter int unsigned T_HOLD   = 2,
  parameter int unsigned T_CMD    = 2000,
  parameter int unsigned T_CLR    = 82000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        rw,
  output logic        en,
  output logic        rs,
  output logic [7:0]  db
);

  localparam int unsigned T_MAX = (T_CLR > T_CMD) ? T_CLR : T_CMD;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(T_EN - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLR_LD   = CW'(T_CLR - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          rs_q_r;
  logic [7:0]    byte_q_r;
  logic          long_r;
  logic          low_nib_r;
  logic          unused_s;

  // Clear (0x01) and return-home (0x02/0x03) commands need the long busy wait.
  function automatic logic is_long_cmd(input logic rs_in, input logic [7:0] b);
    return (rs_in == 1'b0) && (b[7:2] == 6'b000000) && (b[1:0] != 2'b00);
  endfunction

  // Bus value for the current transfer; in 4-bit mode the nibble rides on db[7:4].
  function automatic logic [7:0] bus_value(input logic [7:0] b, input logic low_nib);
    logic [7:0] v;
    if (FOUR_BIT == 32'd0) begin
      v = b;
    end else if (low_nib) begin
      v = {b[3:0], 4'h0};
    end else begin
      v = {b[7:4], 4'h0};
    end
    return v;
  endfunction

  assign rw       = 1'b0;
  assign unused_s = ^{dataa[31:1], datab[31:8]};

  // Write engine: sequencing, shared phase counter and all registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      rs_q_r    <= 1'b0;
      byte_q_r  <= 8'h00;
      long_r    <= 1'b0;
      low_nib_r <= 1'b0;
      en        <= 1'b0;
      rs        <= 1'b0;
      db        <= 8'h00;
      done      <= 1'b0;
      result    <= 32'h0000_0000;
    end else begin
      done   <= 1'b0;
      result <= 32'h0000_0000;
      case (state_r)
        ST_IDLE: begin
          if (clk_en && start) begin
            rs_q_r    <= dataa[0];
            byte_q_r  <= datab[7:0];
            long_r    <= is_long_cmd(dataa[0], datab[7:0]);
            low_nib_r <= 1'b0;
            rs        <= dataa[0];
            db        <= bus_value(datab[7:0], 1'b0);
            en        <= 1'b0;
            cnt_r     <= SETUP_LD;
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_r == '0) begin
            en      <= 1'b1;
            cnt_r   <= EN_LD;
            state_r <= ST_EN_HI;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_EN_HI: begin
          if (cnt_r == '0) begin
            en      <= 1'b0;
            cnt_r   <= HOLD_LD;
            state_r <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if ((FOUR_BIT != 32'd0) && !low_nib_r) begin
            low_nib_r <= 1'b1;
            db        <= bus_value(byte_q_r, 1'b1);
            cnt_r     <= SETUP_LD;
            state_r   <= ST_SETUP;
          end else begin
            cnt_r   <= long_r ? CLR_LD : CMD_LD;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            done    <= 1'b1;
            result  <= {23'h000000, rs_q_r, byte_q_r};
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          en      <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
